// File: rtl/link_pkg.sv
// Shared constants and receiver state encoding for the inter-board link.
package link_pkg;
    localparam int LINK_DATA_W  = 6;
    localparam int MESSAGE_SIZE = 120;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RECV   = 2'd1,
        COMMIT = 2'd2
    } rx_state_t;
endpackage

// File: rtl/toggle_sync_detect.sv
// Synchronises {req, sof, din} from the mainboard and flags each req level change as one beat.
module toggle_sync_detect #(
    parameter int DATA_W      = 6,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_i,
    input  logic              sof_i,
    input  logic [DATA_W-1:0] din_i,
    input  logic              consume_i,
    output logic              beat_edge_o,
    output logic              req_sync_o,
    output logic              sof_sync_o,
    output logic [DATA_W-1:0] din_sync_o
);
    localparam int SW = DATA_W + 2;

    logic [SW-1:0] sync_q [SYNC_STAGES];
    logic          last_req_q;

    // Synchroniser chain; last_req only advances when the beat is consumed so a held-off edge persists
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            last_req_q <= 1'b0;
        end else begin
            sync_q[0] <= {req_i, sof_i, din_i};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            if (consume_i) begin
                last_req_q <= req_sync_o;
            end else begin
                last_req_q <= last_req_q;
            end
        end
    end

    assign {req_sync_o, sof_sync_o, din_sync_o} = sync_q[SYNC_STAGES-1];
    assign beat_edge_o = req_sync_o ^ last_req_q;
endmodule

// File: rtl/link_frame_receiver.sv
// Assembles toggle-handshaked beats into a checksummed datagram and publishes it atomically.
module link_frame_receiver
    import link_pkg::*;
#(
    parameter int DATA_W      = LINK_DATA_W,
    parameter int MSG_W       = MESSAGE_SIZE,
    parameter bit CHECKSUM_EN = 1'b1,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic [DATA_W-1:0] din,
    input  logic              sof,
    output logic              ack,
    output logic [MSG_W-1:0]  read_buffer,
    output logic              frame_valid,
    output logic              frame_err,
    output logic [15:0]       frame_cnt,
    output logic [7:0]        err_cnt
);
    localparam int BEATS    = (MSG_W + DATA_W - 1) / DATA_W;
    localparam int TOTAL    = BEATS + (CHECKSUM_EN ? 1 : 0);
    localparam int SHADOW_W = BEATS * DATA_W;
    localparam int IDX_W    = $clog2(TOTAL + 1);

    logic              beat_edge_s;
    logic              req_sync_s;
    logic              sof_sync_s;
    logic [DATA_W-1:0] din_sync_s;
    logic              consume_s;

    rx_state_t         state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] xor_q, xor_d;
    logic              chk_ok_q, chk_ok_d;
    logic [SHADOW_W-1:0] shadow_q, shadow_d;
    logic [MSG_W-1:0]  rb_q, rb_d;
    logic              fv_q, fv_d;
    logic              fe_q, fe_d;
    logic [15:0]       fcnt_q, fcnt_d;
    logic [7:0]        ecnt_q, ecnt_d;
    logic              ack_q, ack_d;
    logic              start_s;

    toggle_sync_detect #(
        .DATA_W     (DATA_W),
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk        (clk),
        .rst        (rst),
        .req_i      (req),
        .sof_i      (sof),
        .din_i      (din),
        .consume_i  (consume_s),
        .beat_edge_o(beat_edge_s),
        .req_sync_o (req_sync_s),
        .sof_sync_o (sof_sync_s),
        .din_sync_o (din_sync_s)
    );

    // A beat arriving during COMMIT stays pending until the following IDLE cycle
    assign consume_s = beat_edge_s && (state_q != COMMIT);

    // Frame FSM, shadow assembly, checksum and counters
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        xor_d    = xor_q;
        chk_ok_d = chk_ok_q;
        shadow_d = shadow_q;
        rb_d     = rb_q;
        fv_d     = 1'b0;
        fe_d     = 1'b0;
        fcnt_d   = fcnt_q;
        ack_d    = ack_q;
        start_s  = 1'b0;

        if (consume_s) begin
            ack_d = req_sync_s;
        end else begin
            ack_d = ack_q;
        end

        case (state_q)
            IDLE: begin
                if (consume_s) begin
                    if (sof_sync_s) begin
                        start_s = 1'b1;
                    end else begin
                        fe_d = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RECV: begin
                if (consume_s) begin
                    if (sof_sync_s) begin
                        fe_d    = 1'b1;
                        start_s = 1'b1;
                    end else if (idx_q < IDX_W'(BEATS)) begin
                        for (int k = 0; k < BEATS; k++) begin
                            if (idx_q == IDX_W'(k)) begin
                                shadow_d[k*DATA_W +: DATA_W] = din_sync_s;
                            end else begin
                                shadow_d[k*DATA_W +: DATA_W] = shadow_d[k*DATA_W +: DATA_W];
                            end
                        end
                        xor_d = xor_q ^ din_sync_s;
                        idx_d = idx_q + IDX_W'(1);
                        if (idx_q == IDX_W'(TOTAL - 1)) begin
                            state_d = COMMIT;
                        end else begin
                            state_d = RECV;
                        end
                    end else begin
                        chk_ok_d = (din_sync_s == xor_q);
                        state_d  = COMMIT;
                    end
                end else begin
                    state_d = RECV;
                end
            end
            COMMIT: begin
                if (!CHECKSUM_EN || chk_ok_q) begin
                    rb_d   = shadow_q[MSG_W-1:0];
                    fv_d   = 1'b1;
                    fcnt_d = fcnt_q + 16'd1;
                end else begin
                    fe_d = 1'b1;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (start_s) begin
            shadow_d                = '0;
            shadow_d[DATA_W-1:0]    = din_sync_s;
            idx_d                   = IDX_W'(1);
            xor_d                   = din_sync_s;
            chk_ok_d                = 1'b1;
            state_d                 = (TOTAL == 1) ? COMMIT : RECV;
        end else begin
            idx_d = idx_d;
        end

        if (fe_d && (ecnt_q != 8'hFF)) begin
            ecnt_d = ecnt_q + 8'd1;
        end else begin
            ecnt_d = ecnt_q;
        end
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            xor_q    <= '0;
            chk_ok_q <= 1'b0;
            shadow_q <= '0;
            rb_q     <= '0;
            fv_q     <= 1'b0;
            fe_q     <= 1'b0;
            fcnt_q   <= 16'd0;
            ecnt_q   <= 8'd0;
            ack_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            xor_q    <= xor_d;
            chk_ok_q <= chk_ok_d;
            shadow_q <= shadow_d;
            rb_q     <= rb_d;
            fv_q     <= fv_d;
            fe_q     <= fe_d;
            fcnt_q   <= fcnt_d;
            ecnt_q   <= ecnt_d;
            ack_q    <= ack_d;
        end
    end

    assign ack         = ack_q;
    assign read_buffer = rb_q;
    assign frame_valid = fv_q;
    assign frame_err   = fe_q;
    assign frame_cnt   = fcnt_q;
    assign err_cnt     = ecnt_q;
endmodule

// File: doc/link_frame_receiver.md
# link_frame_receiver

Parametrised successor to the childboard's one-way inter-board receiver. Accepts DATA_W-bit beats from the mainboard over a two-phase toggle req/ack handshake and assembles them into an MSG_W-bit datagram. Adds start-of-frame framing, an XOR checksum beat, and atomic double-buffered publication to the output interface. Adds frame/error counters for board bring-up.

## Interface
- DATA_W, 6: link data width per beat.
- MSG_W, 120: datagram width; BEATS = ceil(MSG_W/DATA_W) data beats.
- CHECKSUM_EN, 1: 1 = one extra checksum beat per frame; 0 = no check.
- SYNC_STAGES, 2: synchroniser depth on req, din and sof (≥2).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- req  in  1  toggle; each level change announces one beat.
- din  in  DATA_W  beat data; stable from before the req toggle until the matching ack toggle.
- sof  in  1  start-of-frame flag, qualified like din.
- ack  out  1  toggle; mirrors the req level once the beat is consumed.
- read_buffer  out  MSG_W  last good datagram, held.
- frame_valid  out  1  one-cycle pulse when read_buffer updates.
- frame_err  out  1  one-cycle pulse on a checksum fail or framing error.
- frame_cnt  out  16  good frames, wrapping.
- err_cnt  out  8  errors, saturating at 255.

## Operation
- Beat detect: req synchronised through SYNC_STAGES flops; edge = synced req ≠ last_req. On edge, sample synced din/sof, update last_req, and set ack ← synced req on the next clock. Every beat is acked, including discarded ones, so the link never deadlocks.
- States: IDLE, RECV, COMMIT.
  - IDLE: beat with sof=1 → store at chunk 0, idx=1, xor=din, go to RECV (or COMMIT if total beats = 1). Beat with sof=0 → discard, frame_err, err_cnt++.
  - RECV: beat with sof=0 → store at chunk idx, xor ^= din, idx++. After the last data beat, if CHECKSUM_EN, the next beat is compared against xor. The last beat goes to COMMIT.
  - RECV, beat with sof=1 → abandon the partial frame, frame_err, err_cnt++, restart as in IDLE with this beat as chunk 0.
  - COMMIT (1 cycle): if the checksum matches or CHECKSUM_EN=0 → read_buffer ← shadow, frame_valid, frame_cnt++. Otherwise frame_err, err_cnt++, read_buffer unchanged. Always → IDLE.
- Packing: chunk k occupies shadow bits [k*DATA_W +: DATA_W], chunk 0 at the LSBs. Bits of the final chunk beyond MSG_W are dropped but still included in the xor.
- The shadow register is separate from read_buffer, so read_buffer never shows a partial frame.

## Timing
- Reset values: ack=0, read_buffer=0, frame_valid=0, frame_err=0, frame_cnt=0, err_cnt=0, state=IDLE. Synchroniser and last_req also reset to 0.
- rst is shared by both boards. A reset mid-frame discards the shadow register and returns to IDLE.
- Latency: a req toggle at the pin reaches ack after SYNC_STAGES+1 clocks.
- The last beat is sampled in cycle T. State is COMMIT in T+1, and read_buffer and the pulses update at the end of T+1 (visible at T+2).
- Minimum beat spacing: one full round trip. The sender must not toggle req until it sees the ack toggle.
- A COMMIT cycle cannot coincide with a beat edge. If an edge is detected during COMMIT, it is registered and processed in the following IDLE cycle without loss.
- err_cnt saturates at 255. frame_cnt wraps from 0xFFFF to 0.

## Structure
- Shared package link_pkg: LINK_DATA_W, MESSAGE_SIZE, and the rx_state_t enum {IDLE, RECV, COMMIT}. Top-level defaults come from these constants.
- Sub-module toggle_sync_detect holds the SYNC_STAGES synchroniser on {req, sof, din}, the last_req register and the edge pulse.
- The FSM, shadow register, checksum and counters live in link_frame_receiver.

## Test plan
Bench parameters: DATA_W=6, MSG_W=12, CHECKSUM_EN=1.
- Good frame: beats (sof=1, 0x15), (0, 0x2A), (0, 0x3F) → read_buffer=0xA95, one frame_valid pulse, frame_cnt=1, ack toggles 3 times.
- Bad checksum: (1, 0x15), (0, 0x2A), (0, 0x00) → frame_err pulse, err_cnt=1, read_buffer keeps its prior value.
- Resync: (1, 0x01), then (1, 0x15), (0, 0x2A), (0, 0x3F) → one frame_err, then read_buffer=0xA95.
- Stray beat in IDLE: (0, 0x07) → acked, frame_err, err_cnt=1, no frame_valid.
- Reset mid-frame: after 2 beats assert rst → all outputs 0. A following full good frame publishes correctly.
- Stress: 300 bad frames → err_cnt saturates at 255. Random inter-beat gaps ≥ handshake → no lost or duplicated ack.
